// File: rtl/decode_cycle.sv
// Decode stage of a small RV32I-subset pipeline: register file with write-through
// bypass, combinational instruction decode and immediate extension, and the
// D/E pipeline register that feeds the execute stage.
module decode_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic        RegWriteW,
    input  logic [4:0]  RDW,
    input  logic [31:0] ResultW,
    input  logic        FlushE,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic        ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  RDE,
    output logic [4:0]  RS1E,
    output logic [4:0]  RS2E
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    // ALU operation for R-type / I-ALU; bit 30 selects sub only for R-type
    function automatic logic [2:0] alu_sel(input logic [2:0] funct3,
                                           input logic       is_rtype,
                                           input logic       bit30);
        case (funct3)
            3'b000:  alu_sel = (is_rtype && bit30) ? 3'b001 : 3'b000;
            3'b010:  alu_sel = 3'b101;
            3'b110:  alu_sel = 3'b011;
            3'b111:  alu_sel = 3'b010;
            default: alu_sel = 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] instr);
        imm_i = {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] instr);
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] instr);
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

    logic [31:0] rf_r [32];

    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;
    logic        wr_en_s;

    logic        reg_write_s;
    logic        mem_write_s;
    logic        branch_s;
    logic        alu_src_s;
    logic        result_src_s;
    logic [2:0]  alu_ctrl_s;
    logic [31:0] imm_ext_s;

    assign rs1_s   = InstrD[19:15];
    assign rs2_s   = InstrD[24:20];
    assign wr_en_s = RegWriteW && (RDW != 5'd0);

    // Register file storage: cleared on reset, x0 never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            rf_r[RDW] <= ResultW;
        end
    end

    // Read ports: x0 hard-wired to zero, same-cycle writeback forwarded
    always_comb begin
        rd1_s = 32'd0;
        rd2_s = 32'd0;
        if (rs1_s == 5'd0) begin
            rd1_s = 32'd0;
        end else if (wr_en_s && (RDW == rs1_s)) begin
            rd1_s = ResultW;
        end else begin
            rd1_s = rf_r[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            rd2_s = 32'd0;
        end else if (wr_en_s && (RDW == rs2_s)) begin
            rd2_s = ResultW;
        end else begin
            rd2_s = rf_r[rs2_s];
        end
    end

    // Control and immediate decode from the opcode; unknown opcodes become a bubble
    always_comb begin
        reg_write_s  = 1'b0;
        mem_write_s  = 1'b0;
        branch_s     = 1'b0;
        alu_src_s    = 1'b0;
        result_src_s = 1'b0;
        alu_ctrl_s   = 3'b000;
        imm_ext_s    = 32'd0;
        case (InstrD[6:0])
            OP_LW: begin
                reg_write_s  = 1'b1;
                alu_src_s    = 1'b1;
                result_src_s = 1'b1;
                imm_ext_s    = imm_i(InstrD);
            end
            OP_SW: begin
                mem_write_s = 1'b1;
                alu_src_s   = 1'b1;
                imm_ext_s   = imm_s(InstrD);
            end
            OP_R: begin
                reg_write_s = 1'b1;
                alu_ctrl_s  = alu_sel(InstrD[14:12], 1'b1, InstrD[30]);
            end
            OP_IALU: begin
                reg_write_s = 1'b1;
                alu_src_s   = 1'b1;
                imm_ext_s   = imm_i(InstrD);
                alu_ctrl_s  = alu_sel(InstrD[14:12], 1'b0, InstrD[30]);
            end
            OP_BEQ: begin
                branch_s   = 1'b1;
                alu_ctrl_s = 3'b001;
                imm_ext_s  = imm_b(InstrD);
            end
            default: begin
                reg_write_s  = 1'b0;
                mem_write_s  = 1'b0;
                branch_s     = 1'b0;
                alu_src_s    = 1'b0;
                result_src_s = 1'b0;
                alu_ctrl_s   = 3'b000;
                imm_ext_s    = 32'd0;
            end
        endcase
    end

    // D/E pipeline register: reset or flush loads an all-zero bubble
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 1'b0;
            ALUControlE <= 3'b000;
            RD1E        <= 32'd0;
            RD2E        <= 32'd0;
            ImmExtE     <= 32'd0;
            PCE         <= 32'd0;
            PCPlus4E    <= 32'd0;
            RDE         <= 5'd0;
            RS1E        <= 5'd0;
            RS2E        <= 5'd0;
        end else if (FlushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= 1'b0;
            ALUControlE <= 3'b000;
            RD1E        <= 32'd0;
            RD2E        <= 32'd0;
            ImmExtE     <= 32'd0;
            PCE         <= 32'd0;
            PCPlus4E    <= 32'd0;
            RDE         <= 5'd0;
            RS1E        <= 5'd0;
            RS2E        <= 5'd0;
        end else begin
            RegWriteE   <= reg_write_s;
            MemWriteE   <= mem_write_s;
            BranchE     <= branch_s;
            ALUSrcE     <= alu_src_s;
            ResultSrcE  <= result_src_s;
            ALUControlE <= alu_ctrl_s;
            RD1E        <= rd1_s;
            RD2E        <= rd2_s;
            ImmExtE     <= imm_ext_s;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            RDE         <= InstrD[11:7];
            RS1E        <= rs1_s;
            RS2E        <= rs2_s;
        end
    end

endmodule
